// File: rtl/spi_master_tx_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_master_tx_rx
//
// SPI mode-0 (CPOL=0, CPHA=0) master, MSB first. Everything runs in the
// clk_100mhz domain. SCLK is a registered output toggled by a half-period
// counter, so the serial clock never forms a second clock domain.
//
// A frame walks through IDLE -> XFER -> HOLD -> GAP -> IDLE:
//   IDLE : tx_ready high. An accept (tx_valid & tx_ready) latches tx_data.
//   XFER : DATA_W bits. Each bit is a low phase then a high phase, each
//          HALF_PERIOD cycles long. MISO is sampled when sclk is driven high.
//          MOSI advances when sclk is driven low, except after the last bit.
//   HOLD : HALF_PERIOD cycles with cs_n low and sclk low. The last bit stays
//          on mosi.
//   GAP  : HALF_PERIOD cycles with cs_n high. This is the minimum deselect
//          time between frames.
// rx_data is loaded, and rx_valid strobes for one cycle, on the same edge
// that releases cs_n.
//
// Parameters
//   DATA_W      : bits per transfer (2..32)
//   HALF_PERIOD : clk_100mhz cycles per SCLK half-period (>= 2)
//
// Ports
//   clk_100mhz : system clock
//   reset_n    : asynchronous active-low reset
//   tx_data    : word to transmit, captured on accept
//   tx_valid   : request to start a transfer
//   tx_ready   : high only in IDLE
//   rx_data    : last received word, held until the next rx_valid
//   rx_valid   : one-cycle strobe when rx_data updates
//   busy       : high from the cycle after accept through the end of GAP
//   sclk       : serial clock, idles low
//   mosi       : serial data out
//   miso       : serial data in
//   cs_n       : chip select, active low
// -----------------------------------------------------------------------------
module spi_master_tx_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned HALF_PERIOD = 10
) (
   input  logic              clk_100mhz,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   localparam int unsigned HCNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
   localparam int unsigned TXS_W  = DATA_W - 1;

   localparam logic [HCNT_W-1:0] HALF_LAST = HCNT_W'(HALF_PERIOD - 1);
   localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_W - 1);
   localparam logic [BCNT_W-1:0] BIT_DONE  = BCNT_W'(DATA_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      HOLD = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t              state;
   logic [HCNT_W-1:0]   half_cnt;
   logic [BCNT_W-1:0]   bit_cnt;
   // The MSB goes straight to mosi on accept, so only the remaining bits are held here.
   logic [TXS_W-1:0]    tx_shift;
   logic [DATA_W-1:0]   rx_shift;
   logic                half_done;

   // Terminal count of the current half-period (low phase, high phase, HOLD or GAP).
   assign half_done = (half_cnt == HALF_LAST);

   // Frame sequencer. All outputs are registered here.
   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         half_cnt <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
      end else begin
         rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               half_cnt <= '0;
               bit_cnt  <= '0;
               sclk     <= 1'b0;
               if (tx_valid && tx_ready) begin
                  tx_shift <= tx_data[TXS_W-1:0];
                  rx_shift <= '0;
                  mosi     <= tx_data[DATA_W-1];
                  cs_n     <= 1'b0;
                  busy     <= 1'b1;
                  tx_ready <= 1'b0;
                  state    <= XFER;
               end
            end

            XFER: begin
               if (half_done) begin
                  half_cnt <= '0;
                  if (!sclk) begin
                     // Rising edge: the slave's data has been stable for the whole low phase.
                     sclk     <= 1'b1;
                     rx_shift <= {rx_shift[DATA_W-2:0], miso};
                  end else begin
                     // Falling edge: close the bit. Present the next bit unless this was the last.
                     sclk <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= BIT_DONE;
                        state   <= HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt + BCNT_W'(1);
                        mosi     <= tx_shift[TXS_W-1];
                        tx_shift <= tx_shift << 1;
                     end
                  end
               end else begin
                  half_cnt <= half_cnt + HCNT_W'(1);
               end
            end

            HOLD: begin
               if (half_done) begin
                  half_cnt <= '0;
                  cs_n     <= 1'b1;
                  mosi     <= 1'b0;
                  rx_data  <= rx_shift;
                  rx_valid <= 1'b1;
                  state    <= GAP;
               end else begin
                  half_cnt <= half_cnt + HCNT_W'(1);
               end
            end

            GAP: begin
               if (half_done) begin
                  half_cnt <= '0;
                  bit_cnt  <= '0;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  half_cnt <= half_cnt + HCNT_W'(1);
               end
            end

            default: begin
               // Unreachable encodings fall back to a clean idle.
               state    <= IDLE;
               half_cnt <= '0;
               bit_cnt  <= '0;
               sclk     <= 1'b0;
               mosi     <= 1'b0;
               cs_n     <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_master_tx_rx.md
Name: spi_master_tx_rx

Overview:
- SPI mode-0 master, MSB first; consumes the 5 MHz serial-clock rate that the clock-divider stage defines.
- Runs entirely in the 100 MHz domain: SCLK is generated internally as a registered output from a half-period counter, so no second clock domain exists.
- Takes parallel words from the controller over a valid/ready handshake, shifts them out on MOSI, shifts MISO in, and returns the received word with a one-cycle strobe.

Parameters:
- DATA_W, 8: bits per transfer; legal range 2..32.
- HALF_PERIOD, 10: clk_100mhz cycles per SCLK half-period; legal minimum 2; default gives SCLK = 5 MHz.

Ports:
- clk_100mhz  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to transmit; captured on accept.
- tx_valid  input  1  request to start a transfer.
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready.
- rx_data  output  DATA_W  last received word; held until the next rx_valid.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- busy  output  1  high from the cycle after accept through the end of GAP.
- sclk  output  1  serial clock; idles low (CPOL=0).
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- cs_n  output  1  chip select, active low.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=1; all counters and shift registers cleared.
- States: IDLE -> XFER -> HOLD -> GAP -> IDLE.
- IDLE:
  - tx_ready=1; on accept, latch tx_data into the shift register.
  - Next cycle: cs_n=0, busy=1, mosi=tx_data[DATA_W-1], sclk=0; enter XFER.
- XFER:
  - Each bit takes 2*HALF_PERIOD cycles: a low phase (HALF_PERIOD cycles) followed by a high phase (HALF_PERIOD cycles).
  - On the cycle sclk is driven 0->1, sample miso into the rx shift register LSB (shift left).
  - On the cycle sclk is driven 1->0, shift mosi to the next bit, except after the last bit.
  - After DATA_W bits (2*HALF_PERIOD*DATA_W cycles), sclk is low; enter HOLD.
- HOLD:
  - HALF_PERIOD cycles with cs_n=0, sclk=0, mosi holding the last bit.
  - Then cs_n=1 and mosi=0.
  - In that same cycle: rx_data <= rx shift register, rx_valid=1 for exactly one cycle; enter GAP.
- GAP: HALF_PERIOD cycles with cs_n=1 (minimum deselect time), then IDLE with tx_ready=1 and busy=0.
- Timing, defaults: cs_n low for 170 cycles; 8 sclk rising edges; sclk period 20 cycles. Accept to rx_valid = 171 cycles. Accept to next tx_ready = 181 cycles.
- tx_valid outside IDLE is ignored; tx_data changes after accept have no effect.
- tx_valid held high continuously: a new transfer is accepted on the first IDLE cycle, giving exactly HALF_PERIOD+1 cycles of cs_n high between frames.
- sclk, mosi and cs_n are registered outputs with no combinational path from inputs.
- Reset asserted mid-transfer: outputs go to reset values immediately and asynchronously; no rx_valid is produced for the aborted frame.
- Counters are sized $clog2(HALF_PERIOD) and $clog2(DATA_W+1); no wrap beyond the terminal counts.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, tx_ready=1, busy=0.
- Loopback (miso=mosi), send 0xA5 -> MOSI bits 1,0,1,0,0,1,0,1 stable at each sclk rise; 8 rises at a 20-cycle period; cs_n low 170 cycles; rx_valid single pulse 171 cycles after accept with rx_data=0xA5.
- miso tied 1, send 0x00 -> mosi=0 throughout; rx_data=0xFF; tx_data changed to 0x77 mid-transfer has no effect on mosi.
- Back-to-back: tx_valid held high with 0x3C then 0xC3 -> two frames; cs_n high exactly 11 cycles between them; rx_valid pulses 181 cycles apart.
- Abort: pulse reset_n low during the high phase of bit 4 -> immediate idle outputs, no rx_valid; a subsequent 0x5A loopback transfer completes normally with rx_data=0x5A.
- Parameter sweep: DATA_W=16, HALF_PERIOD=2, send 0x8001 in loopback -> sclk period 4 cycles; cs_n low 66 cycles; rx_data=0x8001.
